// File: rtl/gb_dma_pkg.sv
// Shared types and address constants for the OAM DMA controller.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] HRAM_TOP     = 16'hFFFE;
  localparam logic [7:0]  ECHO_SUB     = 8'h20;

  // Pages E0-FF alias down into C0-DF (echo RAM).
  function automatic logic [7:0] src_eff(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - ECHO_SUB) : src;
  endfunction

endpackage

// File: rtl/hram_bank.sv
// 127-byte high RAM: synchronous write, asynchronous read.
module hram_bank #(
  parameter int DEPTH = 127
) (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(addr) < DEPTH)) mem_q[addr] <= wdata;
  end

  assign rdata = (int'(addr) < DEPTH) ? mem_q[addr] : 8'h00;

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: FF46 write copies DMA_LEN bytes from {src,00} to FE00.
// Optional HRAM at FF80-FFFE is built when GB_DMA_HRAM_EN is defined.
module oam_dma_ctrl
  import gb_dma_pkg::*;
#(
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam int          CW       = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [CW-1:0] DLY_LOAD = CW'(START_DELAY - 1);
  localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t    state_q;
  logic [7:0]    i_q;
  logic [7:0]    src_q;
  logic [7:0]    byte_q;
  logic [CW-1:0] cnt_q;
  logic          dma_active_q;

  logic reg_hit;
  logic trig;
  logic local_hit;

  assign reg_hit = (cpu_addr == DMA_REG_ADDR);
  assign trig    = cpu_wr && reg_hit;

`ifdef GB_DMA_HRAM_EN
  logic       hram_hit;
  logic [7:0] hram_rdata;

  assign hram_hit = (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_TOP);

  hram_bank #(.DEPTH(127)) u_hram (
    .clk   (clk),
    .we    (cpu_wr && hram_hit),
    .addr  (cpu_addr[6:0]),
    .wdata (cpu_wdata),
    .rdata (hram_rdata)
  );

  assign local_hit = reg_hit || hram_hit;
`else
  assign local_hit = reg_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      i_q          <= 8'h00;
      src_q        <= 8'hFF;
      byte_q       <= 8'h00;
      cnt_q        <= '0;
      dma_active_q <= 1'b0;
    end else if (trig) begin
      src_q        <= cpu_wdata;
      i_q          <= 8'h00;
      cnt_q        <= DLY_LOAD;
      state_q      <= DELAY;
      dma_active_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        DELAY: begin
          if (cnt_q == '0) state_q <= READ;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        READ: begin
          byte_q  <= mem_rdata;
          state_q <= WRITE;
        end
        WRITE: begin
          if (i_q == LAST_IDX) begin
            i_q          <= 8'h00;
            state_q      <= IDLE;
            dma_active_q <= 1'b0;
          end else begin
            i_q     <= i_q + 8'h01;
            state_q <= READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dma_active = dma_active_q;

  // A retrigger in the same cycle suppresses the DMA strobe so the aborted byte never lands.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_rd    = cpu_rd && !local_hit;
          mem_wr    = cpu_wr && !local_hit;
        end
        READ: begin
          mem_addr = {src_eff(src_q), i_q};
          mem_rd   = !trig;
        end
        WRITE: begin
          mem_addr  = OAM_BASE + {8'h00, i_q};
          mem_wdata = byte_q;
          mem_wr    = !trig;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_rdata = mem_rdata;
    if (reg_hit) cpu_rdata = src_q;
`ifdef GB_DMA_HRAM_EN
    else if (hram_hit) cpu_rdata = hram_rdata;
`endif
    else if (dma_active_q) cpu_rdata = 8'hFF;
  end

endmodule
